// File: rtl/reg_writeback_if.sv
// rtl/reg_writeback_if.sv - result handshake and register-bank write bus for reg_writeback
interface reg_writeback_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS)
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [ADDR_W-1:0]   in_addr;
  logic                in_wr_en;
  logic                hold;
  logic                flush;
  logic [DATA_W-1:0]   ALUBus;
  logic [NUM_REGS-1:0] regEnable;
  logic                fwd_valid;
  logic [ADDR_W-1:0]   fwd_addr;
  logic [DATA_W-1:0]   fwd_data;
  logic                busy;
  logic [15:0]         wb_count;

  // Producer / observer side
  modport master (
    output in_valid, in_data, in_addr, in_wr_en, hold, flush,
    input  in_ready, ALUBus, regEnable, fwd_valid, fwd_addr, fwd_data, busy, wb_count
  );

  // Write-back block side
  modport slave (
    input  in_valid, in_data, in_addr, in_wr_en, hold, flush,
    output in_ready, ALUBus, regEnable, fwd_valid, fwd_addr, fwd_data, busy, wb_count
  );
endinterface

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - 2-entry write-back FIFO driving a register bank; optional R0_ZERO_EN keeps r0 unwritten
module reg_writeback #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic          clk,
  input  logic          reset,
  reg_writeback_if.slave wb
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     data0_q, data0_d, data1_q, data1_d;
  logic [ADDR_W-1:0]     addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_W-1:0]     alubus_q, alubus_d;
  logic [NUM_REGS-1:0]   regen_q, regen_d;
  logic                  fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0]     fwd_addr_q, fwd_addr_d;
  logic [DATA_W-1:0]     fwd_data_q, fwd_data_d;
  logic [15:0]           cnt_q, cnt_d;

  logic in_ready;
  logic addr_ok;
  logic accept;
  logic pop;

  // Ready comes only from the registered occupancy so producers see no loop through in_valid/hold
  assign in_ready = (state_q != FULL);

`ifdef R0_ZERO_EN
  assign addr_ok = (wb.in_addr != '0);
`else
  assign addr_ok = 1'b1;
`endif

  // A transfer with in_wr_en=0 (or to a suppressed r0) completes the handshake but is not stored
  assign accept = wb.in_valid && in_ready && wb.in_wr_en && addr_ok && !wb.flush;
  assign pop    = (state_q != EMPTY) && !wb.hold && !wb.flush;

  // Next occupancy, FIFO contents and issue outputs; flush overrides push, pop and hold
  always_comb begin
    state_d     = state_q;
    data0_d     = data0_q;
    addr0_d     = addr0_q;
    data1_d     = data1_q;
    addr1_d     = addr1_q;
    regen_d     = '0;
    alubus_d    = alubus_q;
    fwd_valid_d = fwd_valid_q;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
    cnt_d       = cnt_q;

    if (pop) begin
      regen_d[addr0_q] = 1'b1;
      alubus_d         = data0_q;
      fwd_valid_d      = 1'b1;
      fwd_addr_d       = addr0_q;
      fwd_data_d       = data0_q;
      cnt_d            = cnt_q + 16'd1;
    end

    if (wb.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            data0_d = wb.in_data;
            addr0_d = wb.in_addr;
          end
        end
        ONE: begin
          if (accept && pop) begin
            data0_d = wb.in_data;
            addr0_d = wb.in_addr;
          end else if (accept) begin
            state_d = FULL;
            data1_d = wb.in_data;
            addr1_d = wb.in_addr;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            data0_d = data1_q;
            addr0_d = addr1_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and output registers; reset wins over everything and discards pending entries
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      data0_q     <= '0;
      addr0_q     <= '0;
      data1_q     <= '0;
      addr1_q     <= '0;
      alubus_q    <= '0;
      regen_q     <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      data0_q     <= data0_d;
      addr0_q     <= addr0_d;
      data1_q     <= data1_d;
      addr1_q     <= addr1_d;
      alubus_q    <= alubus_d;
      regen_q     <= regen_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wb.in_ready  = in_ready;
  assign wb.ALUBus    = alubus_q;
  assign wb.regEnable = regen_q;
  assign wb.fwd_valid = fwd_valid_q;
  assign wb.fwd_addr  = fwd_addr_q;
  assign wb.fwd_data  = fwd_data_q;
  assign wb.busy      = (state_q != EMPTY);
  assign wb.wb_count  = cnt_q;
endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - randomized and directed checks of reg_writeback against a queue model
module tb_reg_writeback;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  reg_writeback_if #(.DATA_W(16), .NUM_REGS(16)) bus ();

  reg_writeback #(.DATA_W(16), .NUM_REGS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus.slave)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         q[$];
  logic [15:0] exp_en, exp_bus, exp_fd, exp_cnt;
  logic        exp_fv;
  logic [3:0]  exp_fa;
  logic        accepted;
  int          issued;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] a,
                       input logic we, input logic h, input logic f);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_addr  = a;
    bus.in_wr_en = we;
    bus.hold     = h;
    bus.flush    = f;
  endtask

  // Reference: pending writes form a queue of at most two; one edge pops the head then appends
  task automatic model_edge();
    int  sz;
    wr_t e;
    logic ok;
    accepted = 1'b0;
    sz = q.size();
    ok = 1'b1;
`ifdef R0_ZERO_EN
    ok = (bus.in_addr != 4'd0);
`endif
    if (reset) begin
      q.delete();
      exp_en = 0; exp_bus = 0; exp_fv = 0; exp_fa = 0; exp_fd = 0; exp_cnt = 0;
    end else if (bus.flush) begin
      q.delete();
      exp_en = 0;
    end else begin
      exp_en = 0;
      if (sz > 0 && !bus.hold) begin
        e = q.pop_front();
        exp_en  = 16'h1 << e.addr;
        exp_bus = e.data;
        exp_fv  = 1'b1;
        exp_fa  = e.addr;
        exp_fd  = e.data;
        exp_cnt = exp_cnt + 16'd1;
        issued++;
      end
      if (bus.in_valid && sz < 2) begin
        accepted = 1'b1;
        if (bus.in_wr_en && ok) begin
          e.addr = bus.in_addr;
          e.data = bus.in_data;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("regEnable", 32'(bus.regEnable), 32'(exp_en));
    check("ALUBus",    32'(bus.ALUBus),    32'(exp_bus));
    check("fwd_valid", 32'(bus.fwd_valid), 32'(exp_fv));
    check("fwd_addr",  32'(bus.fwd_addr),  32'(exp_fa));
    check("fwd_data",  32'(bus.fwd_data),  32'(exp_fd));
    check("wb_count",  32'(bus.wb_count),  32'(exp_cnt));
    check("busy",      32'(bus.busy),      32'(q.size() != 0));
    check("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
  endtask

  logic [15:0] r0_exp_en;
  logic [15:0] cnt_snap;
  int          pushed;
  int          cyc;

  initial begin
`ifdef R0_ZERO_EN
    r0_exp_en = 16'h0000;
`else
    r0_exp_en = 16'h0001;
`endif
    issued = 0;
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(); step();
    check("reset_regEnable", 32'(bus.regEnable), 32'h0);
    check("reset_wb_count",  32'(bus.wb_count),  32'h0);
    reset = 1'b0;
    step();
    check("ready_after_reset", 32'(bus.in_ready), 32'h1);

    // Single write to r0: pulse two edges after accept
    drive(1, 16'hFFFF, 4'd0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);           step();
    check("single_regEnable", 32'(bus.regEnable), 32'(r0_exp_en));
    step();
    check("single_pulse_end", 32'(bus.regEnable), 32'h0);

    // Back-to-back under hold, then release
    drive(1, 16'h1234, 4'd3,  1, 1, 0); step();
    drive(1, 16'h5678, 4'd15, 1, 1, 0); step();
    check("full_in_ready", 32'(bus.in_ready), 32'h0);
    check("full_busy",     32'(bus.busy),     32'h1);
    drive(1, 16'h9999, 4'd7, 1, 1, 0);  step();
    drive(0, 0, 0, 0, 0, 0);            step();
    check("drain_r3",  32'(bus.regEnable), 32'h0008);
    check("drain_bus", 32'(bus.ALUBus),    32'h1234);
    step();
    check("drain_r15", 32'(bus.regEnable), 32'h8000);

    // Flush while full with a concurrent transfer attempt
    drive(1, 16'hAAAA, 4'd5, 1, 1, 0); step();
    drive(1, 16'hBBBB, 4'd6, 1, 1, 0); step();
    drive(1, 16'hCCCC, 4'd9, 1, 1, 1); step();
    drive(0, 0, 0, 0, 0, 0);           step();
    check("flush_no_pulse", 32'(bus.regEnable), 32'h0);
    check("flush_busy",     32'(bus.busy),      32'h0);
    check("flush_ready",    32'(bus.in_ready),  32'h1);
    check("flush_fwd_addr", 32'(bus.fwd_addr),  32'd15);

    // Reset while full, then a discarded write
    drive(1, 16'h1111, 4'd1, 1, 1, 0); step();
    drive(1, 16'h2222, 4'd2, 1, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1; step();
    reset = 1'b0;
    check("rst_mid_fwd", 32'(bus.fwd_valid), 32'h0);
    step(); step();
    check("rst_no_pulse", 32'(bus.regEnable), 32'h0);
    cnt_snap = bus.wb_count;
    drive(1, 16'h4444, 4'd4, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);           step(); step();
    check("discard_count", 32'(bus.wb_count), 32'(cnt_snap));

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 1), 16'($urandom), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0));
      step();
    end

    // Counter wrap: 65536 streamed issues from reset bring wb_count back to zero
    reset = 1'b1; drive(0, 0, 0, 0, 0, 0); step();
    reset = 1'b0;
    issued = 0; pushed = 0; cyc = 0;
    while (issued < 65536 && cyc < 70000) begin
      drive(pushed < 65536, 16'($urandom), 4'($urandom_range(1, 15)), 1, 0, 0);
      step();
      if (accepted) pushed++;
      cyc++;
    end
    check("wrap_done", 32'(issued), 32'd65536);
    check("wrap_count", 32'(bus.wb_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
